// File: rtl/imsic_pkg.sv
// ============================================================================
// Module      : imsic_pkg
// Description : Shared types and constants for the IMSIC MSI write responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imsic_pkg;

    // Responder FSM states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GET_W  = 3'd1,
        ST_GET_AW = 3'd2,
        ST_DECODE = 3'd3,
        ST_EMIT   = 3'd4,
        ST_RESP   = 3'd5
    } imsic_msi_state_e;

    // Register offsets inside one 4 KiB interrupt-file page.
    localparam logic [11:0] SETIPNUM_LE_OFF = 12'h000;
    localparam logic [11:0] SETIPNUM_BE_OFF = 12'h004;
    localparam int          IMSIC_PAGE_W    = 12;

    // AXI write response codes.
    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;

    // Byte reversal used by the big-endian setipnum register.
    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/imsic_msi_rx_if.sv
// ============================================================================
// Module      : imsic_msi_rx_if
// Description : AXI4-Lite write channels plus the set-pending request bundle
//               seen by the MSI responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imsic_msi_rx_if #(
    parameter int ADDR_W = 32,
    parameter int FILE_W = 3,
    parameter int ID_W   = 6
);
    logic              i_aw_valid;
    logic              o_aw_ready;
    logic [ADDR_W-1:0] i_aw_addr;
    logic              i_w_valid;
    logic              o_w_ready;
    logic [31:0]       i_w_data;
    logic [3:0]        i_w_strb;
    logic              o_b_valid;
    logic              i_b_ready;
    logic [1:0]        o_b_resp;
    logic              o_set_valid;
    logic              i_set_ready;
    logic [FILE_W-1:0] o_set_file;
    logic [ID_W-1:0]   o_set_id;

    // Responder side.
    modport slave (
        input  i_aw_valid, i_aw_addr, i_w_valid, i_w_data, i_w_strb,
               i_b_ready, i_set_ready,
        output o_aw_ready, o_w_ready, o_b_valid, o_b_resp,
               o_set_valid, o_set_file, o_set_id
    );

    // Initiator / interrupt-file side.
    modport master (
        output i_aw_valid, i_aw_addr, i_w_valid, i_w_data, i_w_strb,
               i_b_ready, i_set_ready,
        input  o_aw_ready, o_w_ready, o_b_valid, o_b_resp,
               o_set_valid, o_set_file, o_set_id
    );
endinterface

`default_nettype wire

// File: rtl/imsic_msi_decode.sv
// ============================================================================
// Module      : imsic_msi_decode
// Description : Combinational MSI decode: address -> interrupt file, data ->
//               identity, plus legality filtering and response code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imsic_msi_decode
    import imsic_pkg::*;
#(
    parameter int              ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h2400_0000,
    parameter int              NR_FILES_TOT = 8,
    parameter int              NR_IDS       = 64,
    parameter int              FILE_W       = $clog2(NR_FILES_TOT),
    parameter int              ID_W         = $clog2(NR_IDS)
) (
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [31:0]       i_data,
    input  wire logic [3:0]        i_strb,
    output logic [FILE_W-1:0]      o_file,
    output logic [ID_W-1:0]        o_id,
    output logic                   o_valid_set,
    output logic [1:0]             o_resp
);

    localparam int                PAGE_W     = ADDR_W - IMSIC_PAGE_W;
    localparam logic [PAGE_W-1:0] c_nr_pages = PAGE_W'(NR_FILES_TOT);
    localparam logic [31:0]       c_nr_ids   = 32'(NR_IDS);

    logic [ADDR_W-1:0]       w_off;
    logic [PAGE_W-1:0]       w_page;
    logic [IMSIC_PAGE_W-1:0] w_reg;
    logic [31:0]             w_id32;
    logic                    w_decerr;
    logic                    w_reg_ok;
    logic                    w_id_ok;

    assign w_off  = i_addr - BASE_ADDR;
    assign w_page = w_off[ADDR_W-1:IMSIC_PAGE_W];
    assign w_reg  = w_off[IMSIC_PAGE_W-1:0];

    // Below the window wraps the subtraction, so it is checked explicitly.
    assign w_decerr = (i_addr < BASE_ADDR) || (w_page >= c_nr_pages);

    assign w_id32   = (w_reg == SETIPNUM_BE_OFF) ? bswap32(i_data) : i_data;
    assign w_reg_ok = (w_reg == SETIPNUM_LE_OFF) || (w_reg == SETIPNUM_BE_OFF);

    // Full 32-bit range check so high garbage bits never alias a legal id.
    assign w_id_ok  = (w_id32 != 32'd0) && (w_id32 < c_nr_ids);

    assign o_valid_set = !w_decerr && w_reg_ok && (i_strb == 4'hF) && w_id_ok;
    assign o_resp      = w_decerr ? AXI_RESP_DECERR : AXI_RESP_OKAY;
    assign o_file      = w_page[FILE_W-1:0];
    assign o_id        = w_id32[ID_W-1:0];

endmodule

`default_nettype wire

// File: rtl/imsic_msi_rx.sv
// ============================================================================
// Module      : imsic_msi_rx
// Description : AXI4-Lite write responder terminating MSIs; emits one
//               set-pending request per legal MSI before returning B.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imsic_msi_rx
    import imsic_pkg::*;
#(
    parameter int                NR_HARTS  = 4,
    parameter int                NR_FILES  = 2,
    parameter int                NR_IDS    = 64,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h2400_0000
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    imsic_msi_rx_if.slave    bus
);

    localparam int NR_FILES_TOT = NR_HARTS * NR_FILES;
    localparam int FILE_W       = $clog2(NR_FILES_TOT);
    localparam int ID_W         = $clog2(NR_IDS);

    imsic_msi_state_e  r_state;
    imsic_msi_state_e  w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [3:0]        r_strb;
    logic [FILE_W-1:0] r_file;
    logic [ID_W-1:0]   r_id;
    logic [1:0]        r_resp;

    logic              w_aw_ready;
    logic              w_w_ready;
    logic              w_set_valid;
    logic              w_b_valid;
    logic              w_aw_hs;
    logic              w_w_hs;

    logic [FILE_W-1:0] w_dec_file;
    logic [ID_W-1:0]   w_dec_id;
    logic              w_dec_valid;
    logic [1:0]        w_dec_resp;

    imsic_msi_decode #(
        .ADDR_W       (ADDR_W),
        .BASE_ADDR    (BASE_ADDR),
        .NR_FILES_TOT (NR_FILES_TOT),
        .NR_IDS       (NR_IDS),
        .FILE_W       (FILE_W),
        .ID_W         (ID_W)
    ) u_decode (
        .i_addr      (r_addr),
        .i_data      (r_data),
        .i_strb      (r_strb),
        .o_file      (w_dec_file),
        .o_id        (w_dec_id),
        .o_valid_set (w_dec_valid),
        .o_resp      (w_dec_resp)
    );

    assign w_aw_hs = w_aw_ready & bus.i_aw_valid;
    assign w_w_hs  = w_w_ready  & bus.i_w_valid;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: one transaction in flight, B only after the set.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_aw_hs && w_w_hs) w_next = ST_DECODE;
                else if (w_aw_hs)      w_next = ST_GET_W;
                else if (w_w_hs)       w_next = ST_GET_AW;
            end
            ST_GET_W:  if (w_w_hs)  w_next = ST_DECODE;
            ST_GET_AW: if (w_aw_hs) w_next = ST_DECODE;
            ST_DECODE: w_next = w_dec_valid ? ST_EMIT : ST_RESP;
            ST_EMIT:   if (bus.i_set_ready) w_next = ST_RESP;
            ST_RESP:   if (bus.i_b_ready)   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Output decode; reset forces every output low within the same cycle.
    always_comb begin
        w_aw_ready  = 1'b0;
        w_w_ready   = 1'b0;
        w_set_valid = 1'b0;
        w_b_valid   = 1'b0;
        if (!i_rst) begin
            case (r_state)
                ST_IDLE: begin
                    w_aw_ready = 1'b1;
                    w_w_ready  = 1'b1;
                end
                ST_GET_W:  w_w_ready   = 1'b1;
                ST_GET_AW: w_aw_ready  = 1'b1;
                ST_EMIT:   w_set_valid = 1'b1;
                ST_RESP:   w_b_valid   = 1'b1;
                default: ;
            endcase
        end
    end

    // Capture AW/W payloads on their handshakes and the decode result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr <= '0;
            r_data <= '0;
            r_strb <= '0;
            r_file <= '0;
            r_id   <= '0;
            r_resp <= AXI_RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_addr <= bus.i_aw_addr;
            end
            if (w_w_hs) begin
                r_data <= bus.i_w_data;
                r_strb <= bus.i_w_strb;
            end
            if (r_state == ST_DECODE) begin
                r_file <= w_dec_file;
                r_id   <= w_dec_id;
                r_resp <= w_dec_resp;
            end
        end
    end

    assign bus.o_aw_ready  = w_aw_ready;
    assign bus.o_w_ready   = w_w_ready;
    assign bus.o_set_valid = w_set_valid;
    assign bus.o_set_file  = w_set_valid ? r_file : '0;
    assign bus.o_set_id    = w_set_valid ? r_id   : '0;
    assign bus.o_b_valid   = w_b_valid;
    assign bus.o_b_resp    = w_b_valid ? r_resp : AXI_RESP_OKAY;

endmodule

`default_nettype wire

// File: tb/tb_imsic_msi_rx.sv
// ============================================================================
// Module      : tb_imsic_msi_rx
// Description : Directed self-checking bench for imsic_msi_rx with a
//               set/B scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imsic_msi_rx;

    typedef struct packed {
        logic [2:0] file;
        logic [5:0] id;
    } set_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc_cnt = 0;

    int   n_vec = 0;
    int   n_err = 0;
    int   set_cnt = 0;
    int   b_cnt = 0;
    int   set_cyc = 0;
    int   b_cyc = 0;
    int   hs_cyc = 0;
    int   n_b_exp = 0;

    set_t       exp_set[$];
    logic [1:0] exp_b[$];

    imsic_msi_rx_if #(.ADDR_W(32), .FILE_W(3), .ID_W(6)) bus ();

    imsic_msi_rx u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: compare every set and B handshake against the queues.
    always @(negedge clk) begin
        if (!rst && bus.o_set_valid && bus.i_set_ready) begin
            set_cnt++;
            set_cyc = cyc_cnt;
            if (exp_set.size() == 0) check("set_unexpected", 32'(exp_set.size()), 32'd1);
            else check("set_file_id", 32'({bus.o_set_file, bus.o_set_id}), 32'(exp_set.pop_front()));
        end
        if (!rst && bus.o_b_valid && bus.i_b_ready) begin
            b_cnt++;
            b_cyc = cyc_cnt;
            if (exp_b.size() == 0) check("b_unexpected", 32'(exp_b.size()), 32'd1);
            else check("b_resp", 32'(bus.o_b_resp), 32'(exp_b.pop_front()));
        end
    end

    // Drive W immediately and AW after aw_lag cycles; records completion cycle.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int aw_lag);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        bus.i_aw_addr  = a;
        bus.i_w_data   = d;
        bus.i_w_strb   = s;
        bus.i_w_valid  = 1'b1;
        bus.i_aw_valid = (aw_lag == 0);
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge clk);
            aw_hs = bus.i_aw_valid && bus.o_aw_ready;
            w_hs  = bus.i_w_valid  && bus.o_w_ready;
            if (w_done && !aw_done) check("w_ready_low_get_aw", 32'(bus.o_w_ready), 32'd0);
            if ((aw_hs || aw_done) && (w_hs || w_done)) hs_cyc = cyc_cnt;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1'b1; bus.i_aw_valid = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; bus.i_w_valid  = 1'b0; end
            cyc++;
            if (!aw_done && cyc == aw_lag) bus.i_aw_valid = 1'b1;
        end
        check("write_hs_done", 32'(aw_done && w_done), 32'd1);
    endtask

    task automatic wait_b(input int target);
        int cyc;
        cyc = 0;
        while (b_cnt < target && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        check("b_wait", 32'(b_cnt), 32'(target));
    endtask

    task automatic push_set(input logic [2:0] f, input logic [5:0] i);
        set_t e;
        e.file = f; e.id = i;
        exp_set.push_back(e);
    endtask

    task automatic push_b(input logic [1:0] r);
        exp_b.push_back(r);
        n_b_exp++;
    endtask

    initial begin
        bit stable;
        bus.i_aw_valid  = 1'b0;
        bus.i_aw_addr   = '0;
        bus.i_w_valid   = 1'b0;
        bus.i_w_data    = '0;
        bus.i_w_strb    = '0;
        bus.i_b_ready   = 1'b1;
        bus.i_set_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({bus.o_aw_ready, bus.o_w_ready, bus.o_set_valid,
                                    bus.o_b_valid, bus.o_b_resp}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'({bus.o_aw_ready, bus.o_w_ready}), 32'b11);
        @(posedge clk); #1;

        // Same-cycle AW+W, minimum latency.
        push_set(3'd1, 6'd5); push_b(2'b00);
        axi_write(32'h2400_1000, 32'h0000_0005, 4'hF, 0);
        wait_b(n_b_exp);
        check("lat_set", 32'(set_cyc - hs_cyc), 32'd2);
        check("lat_b", 32'(b_cyc - hs_cyc), 32'd3);
        check("one_pulse", 32'(set_cnt), 32'd1);
        @(negedge clk);
        check("ready_n4", 32'({bus.o_aw_ready, bus.o_w_ready}), 32'b11);
        @(posedge clk); #1;

        // W first, AW three cycles later; big-endian register.
        push_set(3'd2, 6'd7); push_b(2'b00);
        axi_write(32'h2400_2004, 32'h0700_0000, 4'hF, 3);
        wait_b(n_b_exp);
        @(posedge clk); #1;

        // Decode errors and silently ignored writes.
        push_b(2'b11);
        axi_write(32'h2400_8000, 32'h0000_0005, 4'hF, 0); wait_b(n_b_exp);
        push_b(2'b11);
        axi_write(32'h23FF_F000, 32'h0000_0005, 4'hF, 0); wait_b(n_b_exp);
        push_b(2'b00);
        axi_write(32'h2400_1000, 32'h0000_0000, 4'hF, 0); wait_b(n_b_exp);
        push_b(2'b00);
        axi_write(32'h2400_1000, 32'h0000_0040, 4'hF, 0); wait_b(n_b_exp);
        push_b(2'b00);
        axi_write(32'h2400_1000, 32'h0000_0005, 4'h3, 0); wait_b(n_b_exp);
        push_b(2'b00);
        axi_write(32'h2400_1008, 32'h0000_0005, 4'hF, 0); wait_b(n_b_exp);
        check("no_set_ignored", 32'(set_cnt), 32'd2);

        // Highest legal id on the last file.
        push_set(3'd7, 6'd63); push_b(2'b00);
        axi_write(32'h2400_7000, 32'h0000_003F, 4'hF, 0); wait_b(n_b_exp);
        @(posedge clk); #1;

        // Set stalled for 10 cycles, then B back-pressured.
        bus.i_set_ready = 1'b0;
        push_set(3'd3, 6'd42); push_b(2'b00);
        axi_write(32'h2400_3000, 32'h0000_002A, 4'hF, 0);
        @(posedge clk);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(bus.o_set_valid && bus.o_set_file == 3'd3 &&
                  bus.o_set_id == 6'd42 && !bus.o_b_valid)) stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        @(posedge clk); #1;
        bus.i_set_ready = 1'b1;
        bus.i_b_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b_after_set", 32'(cyc_cnt - set_cyc), 32'd1);
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!(bus.o_b_valid && !bus.o_aw_ready && !bus.o_w_ready)) stable = 1'b0;
            @(negedge clk);
        end
        check("b_hold_ready_low", 32'(stable), 32'd1);
        @(posedge clk); #1;
        bus.i_b_ready = 1'b1;
        wait_b(n_b_exp);
        @(posedge clk); #1;

        // Reset during EMIT drops the transaction without a B.
        bus.i_set_ready = 1'b0;
        axi_write(32'h2400_5000, 32'h0000_0009, 4'hF, 0);
        @(negedge clk);
        @(negedge clk);
        check("emit_before_rst", 32'(bus.o_set_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_outputs_zero", 32'({bus.o_aw_ready, bus.o_w_ready, bus.o_set_valid,
                                       bus.o_b_valid, bus.o_b_resp, bus.o_set_file,
                                       bus.o_set_id}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.i_set_ready = 1'b1;
        @(negedge clk);
        check("idle_after_rst", 32'({bus.o_aw_ready, bus.o_w_ready, bus.o_b_valid}), 32'b110);
        @(posedge clk); #1;
        push_set(3'd0, 6'd3); push_b(2'b00);
        axi_write(32'h2400_0000, 32'h0000_0003, 4'hF, 0);
        wait_b(n_b_exp);
        repeat (5) @(posedge clk);

        check("sets_total", 32'(set_cnt), 32'd5);
        check("b_total", 32'(b_cnt), 32'(n_b_exp));
        check("set_queue_empty", 32'(exp_set.size()), 32'd0);
        check("b_queue_empty", 32'(exp_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imsic_msi_rx.md
Name: imsic_msi_rx

Overview:
- AXI4-Lite write responder on the IMSIC island; terminates MSI writes issued by the APLIC (MSI mode) or any other MSI initiator.
- Decodes the target interrupt file from the address and the identity from the data.
- Emits one set-pending request per valid MSI toward the IMSIC interrupt-file register logic.
- Reads are out of scope; the read channel is tied off in the island wrapper.

Parameters:
- NrHarts, 4, number of harts served.
- NrFiles, 2, interrupt files per hart (M, S).
- NrIds, 64, implemented identities; legal range is 1..NrIds-1.
- AddrW, 32, AXI address width.
- BaseAddr, 32'h2400_0000, window base; 4 KiB-aligned.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_aw_valid  in  1  write-address valid.
- o_aw_ready  out  1  write-address ready.
- i_aw_addr  in  AddrW  write address.
- i_w_valid  in  1  write-data valid.
- o_w_ready  out  1  write-data ready.
- i_w_data  in  32  write data.
- i_w_strb  in  4  byte strobes.
- o_b_valid  out  1  response valid.
- i_b_ready  in  1  response ready.
- o_b_resp  out  2  response code: 00 OKAY, 11 DECERR.
- o_set_valid  out  1  set-pending request.
- i_set_ready  in  1  interrupt file accepts the request.
- o_set_file  out  $clog2(NrHarts*NrFiles)  flat file index, hart*NrFiles+file.
- o_set_id  out  $clog2(NrIds)  identity to set pending.

Behaviour:
- Reset: all outputs 0; state IDLE; captured address/data cleared. Assertion mid-transaction drops it silently; no B is issued afterwards.
- FSM states: IDLE, GET_W, GET_AW, DECODE, EMIT, RESP.
- IDLE: o_aw_ready=1, o_w_ready=1.
  - AW and W handshake the same cycle: go to DECODE.
  - AW only: go to GET_W (o_aw_ready=0, o_w_ready=1).
  - W only: go to GET_AW (o_w_ready=0, o_aw_ready=1).
- GET_W / GET_AW: on the missing handshake, go to DECODE. Only one transaction is outstanding; no pipelining.
- DECODE (single cycle): off = addr - BaseAddr; page = off[AddrW-1:12]; reg = off[11:0].
  - page >= NrHarts*NrFiles, or addr < BaseAddr: resp=DECERR, go to RESP.
  - reg==0x000 (setipnum_le): id = data.
  - reg==0x004 (setipnum_be): id = byte-swapped data.
  - Any other reg: resp=OKAY, go to RESP with no set.
  - Strobe != 4'hF: resp=OKAY, ignored.
  - id==0 or id>=NrIds (full 32-bit compare): resp=OKAY, ignored.
  - Otherwise go to EMIT with file=page and id=id[$clog2(NrIds)-1:0].
- EMIT: o_set_valid=1 with file/id held stable until i_set_ready. On the handshake cycle, go to RESP with resp=OKAY. The set is never dropped while stalled.
- RESP: o_b_valid=1 with o_b_resp held until i_b_ready, then go to IDLE. AW/W ready stay 0 until IDLE.
- Minimum latency, i_set_ready=1 and i_b_ready=1:
  - AW+W handshake at cycle N.
  - o_set_valid at N+2.
  - o_b_valid at N+3.
  - New AW/W accepted from N+4.
- The B response is never issued before the set has been accepted. This gives ordering: a later MSI cannot overtake an earlier one.

Decomposition:
- Shared package imsic_pkg holds:
  - imsic_msi_state_e (FSM enum).
  - constants SETIPNUM_LE_OFF=12'h000, SETIPNUM_BE_OFF=12'h004, IMSIC_PAGE_W=12.
  - AXI resp codes AXI_RESP_OKAY, AXI_RESP_DECERR.
- One natural sub-module: imsic_msi_decode, purely combinational. Inputs addr/data/strb; outputs file, id, valid_set, resp. It is unit-testable on its own; the FSM and channel handshakes stay in imsic_msi_rx.

Test Plan:
- AW addr 0x2400_1000 and W data 0x05 (strb F) in the same cycle, set_ready=1 → at N+2 one set pulse with file=1, id=5; at N+3 B OKAY; exactly one pulse.
- W data 0x0700_0000 at addr 0x2400_2004, AW arriving 3 cycles after W → W taken in IDLE, AW taken in GET_AW; set file=2, id=7; B OKAY.
- Addr 0x2400_8000 (page 8 ≥ 8) → no set; B DECERR.
- Data 0 or data 64, or strb 4'h3, at a valid page → no set; B OKAY.
- i_set_ready held low 10 cycles → o_set_valid and file/id stable throughout, no B; B appears 1 cycle after the set handshake. Then hold i_b_ready low → AW/W ready stay 0 until B completes.
- i_rst asserted during EMIT → all outputs 0 the same cycle; after release, a new MSI addr 0x2400_0000 data 3 → set file=0, id=3; B OKAY; no stale response.
